// File: rtl/ysyx_imem_rsp_pkg.sv
// Shared state encodings, response codes and LFSR step for the instruction-memory responder.
package ysyx_imem_rsp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_t;

    localparam logic [1:0]  RESP_OKAY    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR  = 2'b10;
    localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

    // Right-shifting Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5 feed the new MSB).
    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/ysyx_lfsr16.sv
// Free-running 16-bit maximal-length LFSR, reloaded with SEED on reset.
module ysyx_lfsr16
    import ysyx_imem_rsp_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] value
);

    logic [15:0] lfsr_r;

    // LFSR state register; advances every cycle outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr16_next(lfsr_r);
        end
    end

    assign value = lfsr_r;

endmodule

// File: rtl/ysyx_imem_rsp.sv
// Single-beat instruction fetch responder with fixed or LFSR-randomised latency
// and a byte-strobed write port for loading program contents.
module ysyx_imem_rsp
    import ysyx_imem_rsp_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE      = ADDR_W'(DEFAULT_BASE),
    parameter int                LAT_MODE  = 0,
    parameter int                LATENCY   = 2,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic [1:0]        rresp,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb
);

    localparam int IDX_W = $clog2(DEPTH);

    imem_state_t       state_r;
    imem_state_t       state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] rd_addr_s;
    logic [ADDR_W-1:0] rd_off_s;
    logic [ADDR_W-1:0] wr_off_s;
    logic [IDX_W-1:0]  rd_idx_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic              rd_ok_s;
    logic              wr_ok_s;
    logic              accept_s;
    logic              enter_resp_s;
    logic [3:0]        lat_s;
    logic [15:0]       lfsr_s;
    logic              lfsr_unused_s;
    logic              rvalid_r;
    logic [DATA_W-1:0] rdata_r;
    logic [1:0]        rresp_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return (a >= BASE) && (a[1:0] == 2'b00) && ((off >> 2) < ADDR_W'(DEPTH));
    endfunction

    ysyx_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_s)
    );

    assign lfsr_unused_s = ^lfsr_s[15:4];
    assign lat_s         = (LAT_MODE == 1) ? lfsr_s[3:0] : 4'(LATENCY);
    assign accept_s      = (state_r == IDLE) && arvalid;
    assign enter_resp_s  = (state_s == RESP) && (state_r != RESP);

    assign rd_off_s = rd_addr_s - BASE;
    assign rd_idx_s = rd_off_s[IDX_W+1:2];
    assign rd_ok_s  = addr_ok(rd_addr_s);
    assign wr_off_s = waddr - BASE;
    assign wr_idx_s = wr_off_s[IDX_W+1:2];
    assign wr_ok_s  = addr_ok(waddr);

    // Next-state, countdown and read-address selection (live address for zero-latency hits).
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        rd_addr_s = addr_r;
        case (state_r)
            IDLE: begin
                rd_addr_s = araddr;
                if (arvalid) begin
                    cnt_s   = lat_s;
                    state_s = (lat_s == 4'd0) ? RESP : WAIT;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd1) begin
                    cnt_s   = 4'd0;
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // FSM state, latched request address and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            cnt_r    <= 4'd0;
            addr_r   <= {ADDR_W{1'b0}};
            rvalid_r <= 1'b0;
            rdata_r  <= {DATA_W{1'b0}};
            rresp_r  <= RESP_OKAY;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                addr_r <= araddr;
            end
            // The array is sampled on the edge entering RESP, so a same-edge write is not seen.
            if (enter_resp_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_ok_s ? mem_r[rd_idx_s] : {DATA_W{1'b0}};
                rresp_r  <= rd_ok_s ? RESP_OKAY : RESP_SLVERR;
            end else begin
                rvalid_r <= 1'b0;
                rdata_r  <= {DATA_W{1'b0}};
                rresp_r  <= RESP_OKAY;
            end
        end
    end

    // Byte-strobed write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wen && wr_ok_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem_r[wr_idx_s][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign arready = (state_r == IDLE);
    assign rvalid  = rvalid_r;
    assign rdata   = rdata_r;
    assign rresp   = rresp_r;

endmodule

// File: tb/tb_ysyx_imem_rsp.sv
// Self-checking bench: four responders (latency 0, 3, 5 and LFSR) against a word-array model.
module tb_ysyx_imem_rsp;

    localparam int          N     = 4;
    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         arvalid;
    logic [N-1:0][31:0]   araddr;
    logic [N-1:0]         arready;
    logic [N-1:0][31:0]   rdata;
    logic [N-1:0]         rvalid;
    logic [N-1:0][1:0]    rresp;
    logic [N-1:0]         wen;
    logic [N-1:0][31:0]   waddr;
    logic [N-1:0][31:0]   wdata;
    logic [N-1:0][3:0]    wstrb;

    logic [31:0] model_mem [N][DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ysyx_imem_rsp #(
            .DEPTH    (DEPTH),
            .BASE     (BASE),
            .LAT_MODE ((g == 3) ? 1 : 0),
            .LATENCY  ((g == 0) ? 0 : (g == 1) ? 3 : (g == 2) ? 5 : 2)
        ) u_dut (
            .clk     (clk),
            .rst     (rst),
            .araddr  (araddr[g]),
            .arvalid (arvalid[g]),
            .arready (arready[g]),
            .rdata   (rdata[g]),
            .rvalid  (rvalid[g]),
            .rresp   (rresp[g]),
            .wen     (wen[g]),
            .waddr   (waddr[g]),
            .wdata   (wdata[g]),
            .wstrb   (wstrb[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit valid_addr(input logic [31:0] a);
        return (a >= BASE) && (a < TOP) && (a % 32'd4 == 32'd0);
    endfunction

    task automatic model_read(input int i, input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        if (valid_addr(a)) begin
            d = model_mem[i][int'((a - BASE) / 32'd4)];
            r = 2'b00;
        end else begin
            d = 32'h0;
            r = 2'b10;
        end
    endtask

    task automatic mwrite(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        @(negedge clk);
        wen[i] = 1'b1; waddr[i] = a; wdata[i] = d; wstrb[i] = s;
        @(negedge clk);
        wen[i] = 1'b0;
        if (valid_addr(a)) begin
            idx = int'((a - BASE) / 32'd4);
            for (int b = 0; b < 4; b++)
                if (s[b]) model_mem[i][idx][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // Issue one request at cycle T, move araddr to alt at T+1; lat is the T->rvalid distance.
    task automatic read_req(input int i, input logic [31:0] a, input logic [31:0] alt,
                            output int lat, output logic [31:0] d, output logic [1:0] r);
        lat = 0; d = 32'h0; r = 2'b00;
        @(negedge clk);
        check("arready_before_req", 32'(arready[i]), 32'd1);
        arvalid[i] = 1'b1; araddr[i] = a;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                arvalid[i] = 1'b0; araddr[i] = alt;
            end
            if (rvalid[i]) begin
                lat = k; d = rdata[i]; r = rresp[i];
                break;
            end
        end
        if (lat == 0) begin
            check("read_timeout", 32'd0, 32'd1);
        end else begin
            check("arready_in_resp", 32'(arready[i]), 32'd0);
            @(negedge clk);
            check("rvalid_one_shot", 32'(rvalid[i]), 32'd0);
            check("arready_after_resp", 32'(arready[i]), 32'd1);
            check("rdata_idle_zero", rdata[i], 32'd0);
        end
    endtask

    task automatic read_vs_model(input int i, input string tag, input logic [31:0] a, input int exp_lat);
        int lat;
        logic [31:0] d, ed;
        logic [1:0] r, er;
        read_req(i, a, a + 32'd4, lat, d, r);
        model_read(i, a, ed, er);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, d, ed);
        check({tag, "_resp"}, 32'(r), 32'(er));
    endtask

    initial begin
        int lat, seen, issued, done, cyc, acc_cyc, gap, distinct, pick;
        logic [31:0] d, ed, a;
        logic [1:0] r, er;
        logic [31:0] exp_d[$];
        logic [1:0] exp_r[$];
        bit lat_seen [17];

        rst = 1'b1;
        arvalid = '0; araddr = '0; wen = '0; waddr = '0; wdata = '0; wstrb = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < N; i++) begin
            check("rst_arready", 32'(arready[i]), 32'd1);
            check("rst_rvalid", 32'(rvalid[i]), 32'd0);
            check("rst_rdata", rdata[i], 32'd0);
            check("rst_rresp", 32'(rresp[i]), 32'd0);
        end
        rst = 1'b0;

        // Zero latency: response one cycle after acceptance.
        mwrite(0, BASE, 32'h0000_0413, 4'hF);
        read_req(0, BASE, BASE, lat, d, r);
        check("lat0_lat", 32'(lat), 32'd1);
        check("lat0_data", d, 32'h0000_0413);
        check("lat0_resp", 32'(r), 32'd0);

        // Error decodes.
        read_vs_model(0, "below_base", 32'h7FFF_FFFC, 1);
        read_vs_model(0, "misaligned", 32'h8000_0002, 1);
        read_vs_model(0, "past_top", TOP, 1);

        // Dropped writes must not alias onto any stored word.
        mwrite(0, BASE + 32'd4, 32'h1357_9BDF, 4'hF);
        mwrite(0, TOP - 32'd4, 32'hCAFE_F00D, 4'hF);
        mwrite(0, TOP, 32'hDEAD_BEEF, 4'hF);
        mwrite(0, BASE + 32'd6, 32'hDEAD_BEEF, 4'hF);
        read_vs_model(0, "drop_w0", BASE, 1);
        read_vs_model(0, "drop_w1", BASE + 32'd4, 1);
        read_vs_model(0, "drop_wlast", TOP - 32'd4, 1);

        // Byte strobes.
        mwrite(0, BASE + 32'd8, 32'h1122_3344, 4'hF);
        mwrite(0, BASE + 32'd8, 32'hAABB_CCDD, 4'b0101);
        read_req(0, BASE + 32'd8, BASE, lat, d, r);
        check("strobe_data", d, 32'h11BB_33DD);
        check("strobe_resp", 32'(r), 32'd0);

        // Latency 3: address change after acceptance is ignored.
        mwrite(1, BASE + 32'd4, 32'h0BAD_F00D ^ $urandom(), 4'hF);
        mwrite(1, BASE + 32'd8, 32'h5A5A_A5A5, 4'hF);
        read_req(1, BASE + 32'd4, BASE + 32'd8, lat, d, r);
        model_read(1, BASE + 32'd4, ed, er);
        check("lat3_lat", 32'(lat), 32'd4);
        check("lat3_data", d, ed);
        check("lat3_resp", 32'(r), 32'(er));

        // Latency 5: reset two cycles after acceptance kills the response.
        mwrite(2, BASE + 32'd12, 32'h00C0_FFEE, 4'hF);
        seen = 0;
        @(negedge clk);
        arvalid[2] = 1'b1; araddr[2] = BASE + 32'd12;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) arvalid[2] = 1'b0;
            if (k == 2) rst = 1'b1;
            if (k == 3) begin
                rst = 1'b0;
                check("arready_after_rst", 32'(arready[2]), 32'd1);
            end
            if (rvalid[2]) seen++;
        end
        check("no_rvalid_after_rst", 32'(seen), 32'd0);
        read_vs_model(2, "post_rst", BASE + 32'd12, 6);

        // LFSR latency: back-to-back requests with arvalid held high.
        for (int w = 0; w < 16; w++) mwrite(3, BASE + 32'(4 * w), $urandom(), 4'hF);
        issued = 0; done = 0; cyc = 0; acc_cyc = 0;
        while (done < 200 && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            if (rvalid[3]) begin
                if (exp_d.size() == 0) begin
                    check("rand_unexpected_rvalid", 32'd0, 32'd1);
                end else begin
                    check("rand_data", rdata[3], exp_d.pop_front());
                    check("rand_resp", 32'(rresp[3]), 32'(exp_r.pop_front()));
                    gap = cyc - acc_cyc;
                    check("rand_gap_range", 32'((gap >= 1) && (gap <= 16)), 32'd1);
                    if (gap >= 1 && gap <= 16) lat_seen[gap] = 1'b1;
                end
                done++;
            end
            if (arready[3]) begin
                if (issued < 200) begin
                    pick = $urandom_range(0, 15);
                    a = BASE + 32'(4 * pick);
                    if ($urandom_range(0, 7) == 0) a = a + 32'd1;
                    model_read(3, a, ed, er);
                    exp_d.push_back(ed);
                    exp_r.push_back(er);
                    araddr[3] = a; arvalid[3] = 1'b1;
                    acc_cyc = cyc;
                    issued++;
                end else begin
                    arvalid[3] = 1'b0;
                end
            end else begin
                araddr[3] = $urandom();
            end
        end
        arvalid[3] = 1'b0;
        check("rand_all_done", 32'(done), 32'd200);
        distinct = 0;
        for (int g = 1; g <= 16; g++) if (lat_seen[g]) distinct++;
        check("rand_distinct_lat", 32'(distinct >= 8), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
